uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing the single outbound UART byte stream
//  between the TCP-stack return paths (processed TCP data, TX PHY frames, app responses).
//  Each granted packet is prefixed with one tag byte (TAG_BASE + source index) so the host
//  can demultiplex. Sits inside the UART/TCP mux, in front of the physical UART TX path.
// PARAMETERS
//  DATA_WIDTH  8      byte width of all streams
//  NUM_SRC     3      number of requesting AXI-Stream sources (1..8)
//  TAG_BASE    8'hA0  tag byte for source 0; source i is tagged TAG_BASE+i
// PORTS
//  clk        in   1               system clock
//  rst_n      in   1               asynchronous active-low reset
//  s_tdata    in   NUM_SRC*DW      source data, source i at [i*DW +: DW]
//  s_tvalid   in   NUM_SRC         source valid
//  s_tlast    in   NUM_SRC         source end-of-packet
//  s_tready   out  NUM_SRC         source ready (at most one bit high)
//  m_tdata    out  DW              byte to UART TX
//  m_tvalid   out  1               UART TX valid
//  m_tlast    out  1               last byte of tagged packet
//  m_tready   in   1               UART TX ready
//  grant_idx  out  $clog2(NUM_SRC) current/last granted source (width min 1)
//  busy       out  1               high in HDR or DATA
//  pkt_count  out  16              packets completed, wraps 16'hFFFF->0
// BEHAVIOUR
//  - One clock domain. The clock and reset are the clk and rst_n ports above;
//    reset is asynchronous, active-low.
//  - Reset: state IDLE, rr_ptr=0, grant_idx=0, pkt_count=0.
//    All outputs 0: m_tvalid, m_tlast, m_tdata, s_tready, busy.
//  - FSM IDLE -> HDR -> DATA -> IDLE.
//  - IDLE: m_tvalid=0, s_tready=0.
//    - If any s_tvalid: pick the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//    - Register it into grant_idx; go to HDR.
//  - HDR: m_tvalid=1, m_tdata=TAG_BASE+grant_idx (8-bit wrap), m_tlast=0, s_tready=0.
//    - Held stable until m_tready; on handshake go to DATA.
//  - DATA: combinational pass-through of the granted source only:
//    - m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], m_tlast=s_tlast[g].
//    - s_tready[g]=m_tready; all other s_tready bits 0.
//    - On handshake with s_tlast[g]=1: go to IDLE, rr_ptr<=(g+1)%NUM_SRC, pkt_count++.
//  - Latency: request visible in IDLE at cycle N -> tag byte valid at N+1.
//    - First payload byte may pass at N+2 at the earliest.
//    - At least one IDLE bubble between packets.
//  - Grant changes only in IDLE. Requests from other sources are ignored until the packet ends.
//  - Granted source dropping tvalid mid-packet: m_tvalid follows it low; FSM stays in DATA
//    (no timeout).
//  - Granted source dropping tvalid in HDR: tag is still sent; DATA waits for the source.
//  - m_tready low: stall in HDR/DATA with no state or data change (AXI stability).
//  - Single-beat packet (tlast on first byte): tag + 1 byte, m_tlast on that byte.
//  - NUM_SRC=1: always grants 0; rr_ptr stays 0.
//  - Reset mid-packet: immediate return to IDLE, outputs 0. The downstream packet is
//    truncated; no recovery framing.
// STRUCTURE
//  - uart_mux_pkg holds:
//    - typedef enum logic [1:0] {ARB_IDLE, ARB_HDR, ARB_DATA} arb_state_t
//    - localparam default TAG_BASE
//    - function rr_pick(valid, ptr) returning the next index
//  - No sub-module: FSM, pointer and mux are in this file.
// TESTING
//  1 Reset with all s_tvalid=1 -> m_tvalid=0, s_tready=0, pkt_count=0 until rst_n rises.
//  2 Src1 sends {11,22,33} (tlast on 33), m_tready=1 -> m_tdata A1,11,22,33, m_tlast on 33,
//    pkt_count=1.
//  3 All 3 sources hold 2-byte packets -> tag order A0,A1,A2,A0; each packet uninterrupted.
//  4 m_tready toggles 1/0 during HDR and DATA -> bytes are neither lost nor duplicated;
//    m_tdata is stable while stalled.
//  5 Src0 mid-packet; src2 raises tvalid -> src2 s_tready stays 0 until src0 tlast;
//    src2 then tagged A2.
//  6 Assert rst_n=0 after 2nd byte of a 4-byte packet -> outputs 0 same cycle;
//    after release, next request is sent with its tag.

Source files
------------

// File: rtl/uart_mux_pkg.sv
// Shared types and helpers for the UART/TCP output mux.
// Holds the arbiter state encoding, default tag and round-robin pick.
package uart_mux_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HDR,
        ARB_DATA
    } arb_state_t;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;
    localparam int         MAX_SRC          = 8;

    // First set bit of valid scanning ptr, ptr+1, ... mod n.
    // Scanning downward lets the smallest offset win.
    // Returns ptr when nothing is valid.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] valid,
        input logic [2:0] ptr,
        input int         n
    );
        int idx;
        rr_pick = ptr;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[2:0]]) begin
                    rr_pick = idx[2:0];
                end
            end
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter onto one UART byte stream.
// Each packet is prefixed with a tag byte TAG_BASE + source index.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   s_tdata/s_tvalid/s_tlast   NUM_SRC packed AXI-Stream sources
//   s_tready                   per-source ready, at most one high
//   m_tdata/m_tvalid/m_tlast   tagged stream to UART TX
//   m_tready                   UART TX ready
//   grant_idx                  current/last granted source
//   busy                       high while sending tag or payload
//   pkt_count                  completed packets, wrapping
module uart_tx_arbiter
    import uart_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 3,
    parameter logic [DATA_WIDTH-1:0] TAG_BASE =
        DATA_WIDTH'(TAG_BASE_DEFAULT),
    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [GW-1:0]                 grant_idx,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick;
    logic [GW-1:0] g_next;
    logic          any_req;
    logic          done;

    assign any_req = |s_tvalid;
    assign pick    = GW'(rr_pick(8'(s_tvalid), 3'(rr_ptr), NUM_SRC));

    // Pointer moves to the source after the one just served.
    assign g_next = (int'(grant_idx) == NUM_SRC - 1) ?
                    '0 : grant_idx + 1'b1;

    always_comb begin
        state_nxt = state;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tlast   = 1'b0;
        s_tready  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_nxt = ARB_HDR;
                end
            end
            ARB_HDR: begin
                busy     = 1'b1;
                m_tvalid = 1'b1;
                m_tdata  = TAG_BASE + DATA_WIDTH'(grant_idx);
                if (m_tready) begin
                    state_nxt = ARB_DATA;
                end
            end
            ARB_DATA: begin
                busy     = 1'b1;
                m_tdata  = s_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                m_tvalid = s_tvalid[grant_idx];
                m_tlast  = s_tlast[grant_idx];
                s_tready[grant_idx] = m_tready;
                if (m_tready && s_tvalid[grant_idx]
                    && s_tlast[grant_idx]) begin
                    done      = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            pkt_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && any_req) begin
                grant_idx <= pick;
            end
            if (done) begin
                rr_ptr    <= g_next;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus
// queue-driven packet sequences for arbitration corner cases.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] s_tdata;
    logic [2:0]  s_tvalid;
    logic [2:0]  s_tlast;
    logic [2:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [1:0]  grant_idx;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant_idx (grant_idx),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    typedef struct {
        logic [2:0]  vld;
        logic [2:0]  lst;
        logic [23:0] dat;
        logic        rdy;
        logic        mv;
        logic [7:0]  md;
        logic        ml;
        logic [2:0]  sr;
        logic        bz;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [8:0] sq[3][$];
    logic [8:0] got[$];
    logic [8:0] expq[$];
    logic [2:0] en;
    logic       tog;
    logic       prev_stall;
    logic [7:0] prev_md;
    vec_t       tbl[16];

    function automatic vec_t mk(
        input logic [2:0] vld, input logic [2:0] lst,
        input logic [23:0] dat, input logic rdy,
        input logic mv, input logic [7:0] md, input logic ml,
        input logic [2:0] sr, input logic bz);
        vec_t v;
        v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
        v.mv = mv; v.md = md; v.ml = ml; v.sr = sr; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h",
                     nm, act, req);
        end
    endtask

    task automatic drive_srcs();
        logic [8:0] w;
        for (int i = 0; i < 3; i++) begin
            if (en[i] && sq[i].size() > 0) begin
                w = sq[i][0];
                s_tvalid[i]       = 1'b1;
                s_tdata[i*8 +: 8] = w[7:0];
                s_tlast[i]        = w[8];
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[i*8 +: 8] = 8'h00;
                s_tlast[i]        = 1'b0;
            end
        end
    endtask

    task automatic step();
        if (prev_stall) begin
            chk("stall_hold", 64'({m_tvalid, m_tdata}),
                64'({1'b1, prev_md}));
        end
        chk("tready_onehot", 64'($onehot0(s_tready)), 64'd1);
        prev_stall = m_tvalid && !m_tready;
        prev_md    = m_tdata;
        if (m_tvalid && m_tready) begin
            got.push_back({m_tlast, m_tdata});
        end
        for (int i = 0; i < 3; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                void'(sq[i].pop_front());
            end
        end
        @(negedge clk);
        m_tready = tog ? ~m_tready : 1'b1;
        drive_srcs();
        #1;
    endtask

    task automatic run_until(input int n, input string nm);
        int c = 0;
        while (got.size() < n && c < 200) begin
            step();
            c++;
        end
        chk(nm, 64'(got.size()), 64'(n));
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_len"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            chk($sformatf("%s_b%0d", nm, i),
                64'(got[i]), 64'(expq[i]));
        end
    endtask

    task automatic push_pkt(input int i, input logic [31:0] b,
                            input int n);
        for (int k = 0; k < n; k++) begin
            sq[i].push_back({k == n - 1, b[k*8 +: 8]});
        end
    endtask

    task automatic ex(input logic [7:0] b, input logic l);
        expq.push_back({l, b});
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) sq[i].delete();
        got.delete();
        expq.delete();
        en         = 3'b000;
        tog        = 1'b0;
        prev_stall = 1'b0;
        prev_md    = 8'h00;
        s_tvalid   = 3'b000;
        s_tlast    = 3'b000;
        s_tdata    = 24'h0;
        m_tready   = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        clear_all();

        // Reset held with every source requesting.
        rst_n    = 1'b0;
        s_tvalid = 3'b111;
        s_tlast  = 3'b111;
        s_tdata  = 24'h030201;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_hold",
                64'({m_tvalid, s_tready, busy, pkt_count,
                     grant_idx, m_tdata}), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("first_tag", 64'({m_tvalid, m_tdata, m_tlast}),
            64'({1'b1, 8'hA0, 1'b0}));

        // Cycle-by-cycle vectors.
        tbl[0]  = mk(3'b010, 3'b000, 24'h001100, 1,
                     0, 8'h00, 0, 3'b000, 0);
        tbl[1]  = mk(3'b010, 3'b000, 24'h001100, 1,
                     1, 8'hA1, 0, 3'b000, 1);
        tbl[2]  = mk(3'b010, 3'b000, 24'h001100, 1,
                     1, 8'h11, 0, 3'b010, 1);
        tbl[3]  = mk(3'b010, 3'b000, 24'h002200, 1,
                     1, 8'h22, 0, 3'b010, 1);
        tbl[4]  = mk(3'b010, 3'b010, 24'h003300, 1,
                     1, 8'h33, 1, 3'b010, 1);
        tbl[5]  = mk(3'b000, 3'b000, 24'h000000, 1,
                     0, 8'h00, 0, 3'b000, 0);
        tbl[6]  = mk(3'b100, 3'b100, 24'h5A0000, 0,
                     0, 8'h00, 0, 3'b000, 0);
        tbl[7]  = mk(3'b100, 3'b100, 24'h5A0000, 0,
                     1, 8'hA2, 0, 3'b000, 1);
        tbl[8]  = mk(3'b100, 3'b100, 24'h5A0000, 1,
                     1, 8'hA2, 0, 3'b000, 1);
        tbl[9]  = mk(3'b100, 3'b100, 24'h5A0000, 1,
                     1, 8'h5A, 1, 3'b100, 1);
        tbl[10] = mk(3'b000, 3'b000, 24'h000000, 1,
                     0, 8'h00, 0, 3'b000, 0);
        tbl[11] = mk(3'b001, 3'b000, 24'h000077, 1,
                     0, 8'h00, 0, 3'b000, 0);
        tbl[12] = mk(3'b001, 3'b000, 24'h000077, 1,
                     1, 8'hA0, 0, 3'b000, 1);
        tbl[13] = mk(3'b000, 3'b000, 24'h000077, 1,
                     0, 8'h77, 0, 3'b001, 1);
        tbl[14] = mk(3'b001, 3'b001, 24'h000078, 1,
                     1, 8'h78, 1, 3'b001, 1);
        tbl[15] = mk(3'b000, 3'b000, 24'h000000, 1,
                     0, 8'h00, 0, 3'b000, 0);

        do_reset();
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            s_tvalid = tbl[r].vld;
            s_tlast  = tbl[r].lst;
            s_tdata  = tbl[r].dat;
            m_tready = tbl[r].rdy;
            #1;
            chk($sformatf("vec%0d", r),
                64'({m_tvalid, m_tdata, m_tlast, s_tready, busy}),
                64'({tbl[r].mv, tbl[r].md, tbl[r].ml,
                     tbl[r].sr, tbl[r].bz}));
        end
        chk("vec_pkt_count", 64'(pkt_count), 64'd3);

        // All sources busy: strict rotation, whole packets.
        do_reset();
        push_pkt(0, 32'h0201, 2);
        push_pkt(0, 32'h0403, 2);
        push_pkt(1, 32'h1211, 2);
        push_pkt(2, 32'h2221, 2);
        ex(8'hA0, 0); ex(8'h01, 0); ex(8'h02, 1);
        ex(8'hA1, 0); ex(8'h11, 0); ex(8'h12, 1);
        ex(8'hA2, 0); ex(8'h21, 0); ex(8'h22, 1);
        ex(8'hA0, 0); ex(8'h03, 0); ex(8'h04, 1);
        en = 3'b111;
        drive_srcs();
        #1;
        run_until(12, "rr_timeout");
        cmp_stream("rr");
        step();
        chk("rr_pkt_count", 64'(pkt_count), 64'd4);

        // Downstream back-pressure toggling every cycle.
        do_reset();
        push_pkt(1, 32'h776655, 3);
        ex(8'hA1, 0); ex(8'h55, 0); ex(8'h66, 0); ex(8'h77, 1);
        tog      = 1'b1;
        m_tready = 1'b0;
        en       = 3'b111;
        drive_srcs();
        #1;
        run_until(4, "stall_timeout");
        cmp_stream("stall");

        // Late request from src2 waits for src0 to finish.
        do_reset();
        push_pkt(0, 32'h333231, 3);
        push_pkt(2, 32'h41, 1);
        ex(8'hA0, 0); ex(8'h31, 0); ex(8'h32, 0); ex(8'h33, 1);
        ex(8'hA2, 0); ex(8'h41, 1);
        en = 3'b001;
        drive_srcs();
        #1;
        repeat (3) step();
        en = 3'b101;
        drive_srcs();
        #1;
        begin
            int c = 0;
            while (pkt_count == 16'd0 && c < 100) begin
                chk("src2_blocked", 64'(s_tready[2]), 64'd0);
                step();
                c++;
            end
        end
        run_until(6, "late_timeout");
        cmp_stream("late");

        // Reset in the middle of a packet.
        do_reset();
        push_pkt(0, 32'h64636261, 4);
        en = 3'b001;
        drive_srcs();
        #1;
        run_until(3, "mid_timeout");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out",
            64'({m_tvalid, m_tlast, m_tdata, s_tready,
                 busy, pkt_count}), 64'd0);
        clear_all();
        push_pkt(1, 32'h71, 1);
        ex(8'hA1, 0); ex(8'h71, 1);
        en = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        drive_srcs();
        #1;
        run_until(2, "post_rst_timeout");
        cmp_stream("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
